fx3_stream_in_writer: RTL and testbench

//  Parametrised FX3 slave-FIFO write master (FPGA->host stream-in). Pulls words from a valid/ready

---
 rtl/fx3_stream_in_writer_pkg.sv | 28 ++
 rtl/fx3_stream_in_writer_if.sv | 13 +
 rtl/fx3_stream_in_writer_pin_reg.sv | 39 +++
 rtl/fx3_stream_in_writer.sv | 172 +++++++++++++++++
 tb/tb_fx3_stream_in_writer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fx3_stream_in_writer_pkg.sv
// Shared definitions for the FX3 stream-in writer: FSM encoding, strobe levels and
// master-mode codes used by the mode decoder.
package fx3_stream_in_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_WAIT_FLAGB = 3'd2,
    ST_WRITE      = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_ZLP        = 3'd5
  } state_e;

  // FX3 GPIF strobes are active-low
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [1:0] {
    MM_OFF        = 2'd0,
    MM_STREAM_IN  = 2'd1,
    MM_STREAM_OUT = 2'd2,
    MM_LOOPBACK   = 2'd3
  } master_mode_e;

  // settle and drain timers; ADDR_LAT 1..16, WM_DELAY 0..15
  localparam int TMR_W = 4;

endpackage

// File: rtl/fx3_stream_in_writer_if.sv
// Valid/ready source stream feeding the FX3 writer; master is the source FIFO,
// slave is the writer.
interface fx3_stream_in_writer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/fx3_stream_in_writer_pin_reg.sv
// Output register stage for the FX3 GPIF pins so DQ, strobes and A leave the FPGA
// straight from flops.
module fx3_stream_in_writer_pin_reg
  import fx3_stream_in_writer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dq_d,
  input  logic              slwr_d,
  input  logic              pktend_d,
  input  logic              slcs_d,
  input  logic [ADDR_W-1:0] a_d,
  output logic [DATA_W-1:0] DQ,
  output logic              SLWR,
  output logic              PKTEND,
  output logic              SLCS,
  output logic [ADDR_W-1:0] A
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DQ     <= '0;
      SLWR   <= STROBE_OFF;
      PKTEND <= STROBE_OFF;
      SLCS   <= STROBE_OFF;
      A      <= '0;
    end else begin
      DQ     <= dq_d;
      SLWR   <= slwr_d;
      PKTEND <= pktend_d;
      SLCS   <= slcs_d;
      A      <= a_d;
    end
  end

endmodule

// File: rtl/fx3_stream_in_writer.sv
// FX3 slave-FIFO write master (FPGA->host): pulls words from a valid/ready source and
// drives the GPIF write pins, with watermark drain, short-packet commit and ZLPs.
//
//   state      | meaning
//   IDLE       | stream-in disabled; A loaded from sock_sel on enable
//   SETTLE     | waiting ADDR_LAT cycles for flags of the new socket to become valid
//   WAIT_FLAGB | socket selected, waiting for space above watermark or a pending ZLP
//   WRITE      | accepting words while FLAGB reports space
//   DRAIN      | FLAGB fell; accepting the last WM_DELAY words the FX3 still holds
//   ZLP        | one-cycle PKTEND strobe with no data
module fx3_stream_in_writer
  import fx3_stream_in_writer_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int WM_DELAY  = 0,
  parameter int ADDR_LAT  = 2,
  parameter int PKT_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [ADDR_W-1:0]            sock_sel,
  fx3_stream_in_writer_if.slave        src,
  input  logic                         zlp_req,
  output logic                         zlp_done,
  input  logic                         FLAGA,
  input  logic                         FLAGB,
  output logic [DATA_W-1:0]            DQ,
  output logic                         SLWR,
  output logic                         SLCS,
  output logic                         SLOE,
  output logic                         SLRD,
  output logic                         PKTEND,
  output logic [ADDR_W-1:0]            A,
  output logic [$clog2(PKT_WORDS)-1:0] pkt_cnt,
  output logic [2:0]                   state_dbg
);

  localparam int CW = $clog2(PKT_WORDS);
  localparam logic [CW-1:0]    PKT_LAST    = CW'(PKT_WORDS - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((ADDR_LAT > 0) ? ADDR_LAT - 1 : 0);
  localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(WM_DELAY);

  state_e            state;
  logic [TMR_W-1:0]  settle_cnt;
  logic [TMR_W-1:0]  drain_cnt;
  logic              zlp_pend;
  logic              ready_st;
  logic              accept;
  logic              zlp_go;
  logic [DATA_W-1:0] dq_d;
  logic              slwr_d;
  logic              pktend_d;
  logic              slcs_d;
  logic [ADDR_W-1:0] a_d;

  always_comb begin
    ready_st = 1'b0;
    case (state)
      ST_WRITE: ready_st = FLAGB;
      ST_DRAIN: ready_st = (drain_cnt != '0);
      default:  ready_st = 1'b0;
    endcase
  end

  // FLAGA low is a hard full: nothing is accepted regardless of state
  assign src.s_ready = en & FLAGA & ready_st;
  assign accept      = src.s_valid & src.s_ready;
  assign zlp_go      = (state == ST_WAIT_FLAGB) & en & FLAGA & zlp_pend & (pkt_cnt == '0);

  always_comb begin
    dq_d     = DQ;
    slwr_d   = STROBE_OFF;
    pktend_d = STROBE_OFF;
    slcs_d   = en ? STROBE_ON : STROBE_OFF;
    a_d      = A;
    if (accept) begin
      dq_d     = src.s_data;
      slwr_d   = STROBE_ON;
      pktend_d = src.s_last ? STROBE_ON : STROBE_OFF;
    end
    if (zlp_go) pktend_d = STROBE_ON;
    if (state == ST_IDLE && en) a_d = sock_sel;
  end

  // Leaving stream-in mode always returns to IDLE; otherwise FLAGA low freezes the
  // flag-driven states (IDLE/SETTLE ignore flags since the address is not yet settled).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      drain_cnt  <= '0;
      zlp_pend   <= 1'b0;
      zlp_done   <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      zlp_done <= zlp_go;

      if (zlp_req)     zlp_pend <= 1'b1;
      else if (zlp_go) zlp_pend <= 1'b0;

      if (accept) begin
        if (src.s_last || pkt_cnt == PKT_LAST) pkt_cnt <= '0;
        else                                   pkt_cnt <= pkt_cnt + CW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (en) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (!en)                   state      <= ST_IDLE;
          else if (settle_cnt == '0) state      <= ST_WAIT_FLAGB;
          else                       settle_cnt <= settle_cnt - TMR_W'(1);
        end
        ST_WAIT_FLAGB: begin
          if (!en)        state <= ST_IDLE;
          else if (zlp_go) state <= ST_ZLP;
          else if (FLAGA && FLAGB) state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!en || sock_sel != A) begin
            state <= ST_IDLE;
          end else if (FLAGA && !FLAGB) begin
            if (WM_DELAY > 0) begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= ST_WAIT_FLAGB;
            end
          end
        end
        ST_DRAIN: begin
          if (!en)                              state     <= ST_IDLE;
          else if (accept)                      drain_cnt <= drain_cnt - TMR_W'(1);
          else if (FLAGA && drain_cnt == '0)    state     <= ST_WAIT_FLAGB;
        end
        ST_ZLP: begin
          state <= en ? ST_WAIT_FLAGB : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign state_dbg = state;
  assign SLOE      = STROBE_OFF;
  assign SLRD      = STROBE_OFF;

  fx3_stream_in_writer_pin_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_pin_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .dq_d     (dq_d),
    .slwr_d   (slwr_d),
    .pktend_d (pktend_d),
    .slcs_d   (slcs_d),
    .a_d      (a_d),
    .DQ       (DQ),
    .SLWR     (SLWR),
    .PKTEND   (PKTEND),
    .SLCS     (SLCS),
    .A        (A)
  );

endmodule

// File: tb/tb_fx3_stream_in_writer.sv
// Directed bench for fx3_stream_in_writer with WM_DELAY=3, ADDR_LAT=2, PKT_WORDS=8.
module tb_fx3_stream_in_writer;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  sock_sel;
  logic        zlp_req;
  logic        zlp_done;
  logic        FLAGA;
  logic        FLAGB;
  logic [31:0] DQ;
  logic        SLWR, SLCS, SLOE, SLRD, PKTEND;
  logic [1:0]  A;
  logic [2:0]  pkt_cnt;
  logic [2:0]  state_dbg;

  int n_checks;
  int n_fail;

  fx3_stream_in_writer_if #(.DATA_W(32)) src_if ();

  fx3_stream_in_writer #(
    .DATA_W(32), .ADDR_W(2), .WM_DELAY(3), .ADDR_LAT(2), .PKT_WORDS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sock_sel(sock_sel), .src(src_if),
    .zlp_req(zlp_req), .zlp_done(zlp_done), .FLAGA(FLAGA), .FLAGB(FLAGB),
    .DQ(DQ), .SLWR(SLWR), .SLCS(SLCS), .SLOE(SLOE), .SLRD(SLRD), .PKTEND(PKTEND),
    .A(A), .pkt_cnt(pkt_cnt), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; sock_sel = 2'd0; zlp_req = 1'b0; FLAGA = 1'b1; FLAGB = 1'b1;
    src_if.s_data = 32'h0; src_if.s_valid = 1'b0; src_if.s_last = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // enable on a socket with FLAGB high; after 4 edges the writer sits in WRITE
  task automatic start_stream(input logic [1:0] sock);
    sock_sel = sock; en = 1'b1; FLAGB = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (SLWR !== 1'b1)   begin n_fail++; $display("FAIL reset_slwr: got %b expected 1", SLWR); end
    n_checks++; if (SLCS !== 1'b1)   begin n_fail++; $display("FAIL reset_slcs: got %b expected 1", SLCS); end
    n_checks++; if (SLOE !== 1'b1 || SLRD !== 1'b1) begin n_fail++; $display("FAIL reset_sloe_slrd: got %b%b expected 11", SLOE, SLRD); end
    n_checks++; if (PKTEND !== 1'b1) begin n_fail++; $display("FAIL reset_pktend: got %b expected 1", PKTEND); end
    n_checks++; if (A !== 2'd0)      begin n_fail++; $display("FAIL reset_a: got %0d expected 0", A); end
    n_checks++; if (DQ !== 32'h0)    begin n_fail++; $display("FAIL reset_dq: got %h expected 0", DQ); end
    n_checks++; if (pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
    n_checks++; if (state_dbg !== 3'd0 || zlp_done !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0d/%b expected 0/0", state_dbg, zlp_done); end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    n_checks++; if (state_dbg !== 3'd0 || SLCS !== 1'b1) begin n_fail++; $display("FAIL idle_disabled: got state %0d slcs %b expected 0/1", state_dbg, SLCS); end
  endtask

  task automatic test_first_burst();
    int first_low;
    logic exp_slwr;
    first_low = -1;
    do_reset();
    sock_sel = 2'd2; en = 1'b1;
    src_if.s_valid = 1'b1; src_if.s_data = 32'hA500_0000;
    #1;
    n_checks++; if (src_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL burst_ready_idle: got %b expected 0", src_if.s_ready); end
    for (int k = 1; k <= 15; k++) begin
      step();
      exp_slwr = (k >= 5 && k <= 14) ? 1'b0 : 1'b1;
      n_checks++; if (SLWR !== exp_slwr) begin n_fail++; $display("FAIL burst_slwr k=%0d: got %b expected %b", k, SLWR, exp_slwr); end
      if (SLWR === 1'b0 && first_low < 0) first_low = k;
      if (!exp_slwr) begin
        n_checks++; if (DQ !== 32'hA500_0000 + 32'(k - 5)) begin n_fail++; $display("FAIL burst_dq k=%0d: got %h expected %h", k, DQ, 32'hA500_0000 + 32'(k - 5)); end
      end
      if (k == 1) begin
        n_checks++; if (A !== 2'd2) begin n_fail++; $display("FAIL burst_addr: got %0d expected 2", A); end
      end
      if (k == 5) begin
        n_checks++; if (SLCS !== 1'b0) begin n_fail++; $display("FAIL burst_slcs: got %b expected 0", SLCS); end
      end
      if (k >= 5) begin
        if (k - 4 < 10) src_if.s_data = 32'hA500_0000 + 32'(k - 4);
        else            src_if.s_valid = 1'b0;
      end
      #1;
      n_checks++; if (src_if.s_ready !== (k >= 4)) begin n_fail++; $display("FAIL burst_ready k=%0d: got %b expected %b", k, src_if.s_ready, (k >= 4)); end
    end
    n_checks++; if (first_low !== 5) begin n_fail++; $display("FAIL burst_first_slwr: got %0d expected 5", first_low); end
    n_checks++; if (pkt_cnt !== 3'd2) begin n_fail++; $display("FAIL burst_pkt_cnt: got %0d expected 2", pkt_cnt); end
    // en drops right after a word is accepted: the word is still strobed
    src_if.s_valid = 1'b1; src_if.s_data = 32'hDEAD_0001;
    step();
    n_checks++; if (SLWR !== 1'b0 || DQ !== 32'hDEAD_0001 || SLCS !== 1'b0) begin n_fail++; $display("FAIL endrop_last_word: got slwr %b dq %h slcs %b expected 0 dead0001 0", SLWR, DQ, SLCS); end
    n_checks++; if (pkt_cnt !== 3'd3) begin n_fail++; $display("FAIL endrop_pkt_cnt: got %0d expected 3", pkt_cnt); end
    en = 1'b0;
    #1;
    n_checks++; if (src_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL endrop_ready: got %b expected 0", src_if.s_ready); end
    step();
    n_checks++; if (SLWR !== 1'b1 || SLCS !== 1'b1 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL endrop_idle: got slwr %b slcs %b state %0d expected 1 1 0", SLWR, SLCS, state_dbg); end
    src_if.s_valid = 1'b0;
  endtask

  task automatic test_watermark();
    logic [7:0] acc_pat;
    int w;
    int lows;
    acc_pat = 8'b0011_1011;
    w = 0; lows = 0;
    do_reset();
    start_stream(2'd1);
    n_checks++; if (state_dbg !== 3'd3 || A !== 2'd1) begin n_fail++; $display("FAIL wm_start: got state %0d a %0d expected 3 1", state_dbg, A); end
    src_if.s_valid = 1'b1; src_if.s_data = 32'hB000_0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (src_if.s_ready !== acc_pat[i]) begin n_fail++; $display("FAIL wm_ready i=%0d: got %b expected %b", i, src_if.s_ready, acc_pat[i]); end
      step();
      n_checks++; if (SLWR !== ~acc_pat[i]) begin n_fail++; $display("FAIL wm_slwr i=%0d: got %b expected %b", i, SLWR, ~acc_pat[i]); end
      if (i >= 2 && SLWR === 1'b0) lows++;
      if (acc_pat[i]) begin
        n_checks++; if (DQ !== 32'hB000_0000 + 32'(w)) begin n_fail++; $display("FAIL wm_dq i=%0d: got %h expected %h", i, DQ, 32'hB000_0000 + 32'(w)); end
        w++;
        src_if.s_data = 32'hB000_0000 + 32'(w);
      end
      if (i == 1) FLAGB = 1'b0;
    end
    n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL wm_drain_words: got %0d expected 3", lows); end
    n_checks++; if (state_dbg !== 3'd2 || src_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL wm_end: got state %0d ready %b expected 2 0", state_dbg, src_if.s_ready); end
    n_checks++; if (pkt_cnt !== 3'd5) begin n_fail++; $display("FAIL wm_pkt_cnt: got %0d expected 5", pkt_cnt); end
    // ZLP must stay pending while the packet is partially filled
    zlp_req = 1'b1;
    step();
    zlp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (zlp_done !== 1'b0 || PKTEND !== 1'b1 || state_dbg !== 3'd2) begin n_fail++; $display("FAIL zlp_deferred i=%0d: got done %b pktend %b state %0d expected 0 1 2", i, zlp_done, PKTEND, state_dbg); end
    end
    src_if.s_valid = 1'b0;
  endtask

  task automatic test_short_packet();
    do_reset();
    start_stream(2'd0);
    src_if.s_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      src_if.s_data = 32'hC000_0000 + 32'(k);
      src_if.s_last = (k == 5);
      step();
      n_checks++; if (SLWR !== 1'b0 || DQ !== 32'hC000_0000 + 32'(k)) begin n_fail++; $display("FAIL short_word k=%0d: got slwr %b dq %h expected 0 %h", k, SLWR, DQ, 32'hC000_0000 + 32'(k)); end
      n_checks++; if (PKTEND !== ((k == 5) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL short_pktend k=%0d: got %b expected %b", k, PKTEND, (k == 5) ? 1'b0 : 1'b1); end
      n_checks++; if (pkt_cnt !== ((k == 5) ? 3'd0 : 3'(k))) begin n_fail++; $display("FAIL short_pkt_cnt k=%0d: got %0d expected %0d", k, pkt_cnt, (k == 5) ? 0 : k); end
    end
    src_if.s_valid = 1'b0; src_if.s_last = 1'b0;
    step();
    n_checks++; if (SLWR !== 1'b1 || PKTEND !== 1'b1 || pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL short_after: got slwr %b pktend %b cnt %0d expected 1 1 0", SLWR, PKTEND, pkt_cnt); end
    n_checks++; if (DQ !== 32'hC000_0005) begin n_fail++; $display("FAIL short_dq_hold: got %h expected c0000005", DQ); end
  endtask

  task automatic test_zlp();
    do_reset();
    FLAGB = 1'b0; en = 1'b1; sock_sel = 2'd0;
    repeat (3) step();
    n_checks++; if (state_dbg !== 3'd2) begin n_fail++; $display("FAIL zlp_wait_state: got %0d expected 2", state_dbg); end
    zlp_req = 1'b1;
    step();
    zlp_req = 1'b0;
    n_checks++; if (zlp_done !== 1'b0 || PKTEND !== 1'b1) begin n_fail++; $display("FAIL zlp_pre: got done %b pktend %b expected 0 1", zlp_done, PKTEND); end
    step();
    n_checks++; if (PKTEND !== 1'b0 || SLWR !== 1'b1 || zlp_done !== 1'b1) begin n_fail++; $display("FAIL zlp_strobe: got pktend %b slwr %b done %b expected 0 1 1", PKTEND, SLWR, zlp_done); end
    n_checks++; if (state_dbg !== 3'd5) begin n_fail++; $display("FAIL zlp_state: got %0d expected 5", state_dbg); end
    step();
    n_checks++; if (PKTEND !== 1'b1 || zlp_done !== 1'b0 || state_dbg !== 3'd2) begin n_fail++; $display("FAIL zlp_after: got pktend %b done %b state %0d expected 1 0 2", PKTEND, zlp_done, state_dbg); end
    step();
    n_checks++; if (PKTEND !== 1'b1 || zlp_done !== 1'b0) begin n_fail++; $display("FAIL zlp_once: got pktend %b done %b expected 1 0", PKTEND, zlp_done); end
  endtask

  task automatic test_wrap();
    int wraps;
    logic [2:0] prev;
    wraps = 0; prev = 3'd0;
    do_reset();
    start_stream(2'd3);
    src_if.s_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      src_if.s_data = 32'hD000_0000 + 32'(k);
      step();
      n_checks++; if (SLWR !== 1'b0 || PKTEND !== 1'b1) begin n_fail++; $display("FAIL wrap_strobes k=%0d: got slwr %b pktend %b expected 0 1", k, SLWR, PKTEND); end
      n_checks++; if (pkt_cnt !== 3'(k % 8)) begin n_fail++; $display("FAIL wrap_cnt k=%0d: got %0d expected %0d", k, pkt_cnt, k % 8); end
      if (prev == 3'd7 && pkt_cnt == 3'd0) wraps++;
      prev = pkt_cnt;
    end
    n_checks++; if (wraps !== 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", wraps); end
    n_checks++; if (pkt_cnt !== 3'd4) begin n_fail++; $display("FAIL wrap_final: got %0d expected 4", pkt_cnt); end
    // hard full: FLAGA low blocks writes and freezes state
    FLAGA = 1'b0;
    #1;
    n_checks++; if (src_if.s_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", src_if.s_ready); end
    step();
    n_checks++; if (SLWR !== 1'b1 || state_dbg !== 3'd3) begin n_fail++; $display("FAIL full_hold1: got slwr %b state %0d expected 1 3", SLWR, state_dbg); end
    step();
    n_checks++; if (SLWR !== 1'b1 || pkt_cnt !== 3'd4) begin n_fail++; $display("FAIL full_hold2: got slwr %b cnt %0d expected 1 4", SLWR, pkt_cnt); end
    FLAGA = 1'b1;
    src_if.s_data = 32'hD000_0015;
    step();
    n_checks++; if (SLWR !== 1'b0 || DQ !== 32'hD000_0015 || pkt_cnt !== 3'd5) begin n_fail++; $display("FAIL full_resume: got slwr %b dq %h cnt %0d expected 0 d0000015 5", SLWR, DQ, pkt_cnt); end
  endtask

  task automatic test_reset_mid_write();
    rst_n = 1'b0;
    #1;
    n_checks++; if (SLWR !== 1'b1 || PKTEND !== 1'b1 || SLCS !== 1'b1) begin n_fail++; $display("FAIL midrst_strobes: got slwr %b pktend %b slcs %b expected 1 1 1", SLWR, PKTEND, SLCS); end
    n_checks++; if (A !== 2'd0 || pkt_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_a_cnt: got a %0d cnt %0d expected 0 0", A, pkt_cnt); end
    n_checks++; if (DQ !== 32'h0 || state_dbg !== 3'd0) begin n_fail++; $display("FAIL midrst_dq_state: got dq %h state %0d expected 0 0", DQ, state_dbg); end
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_first_burst();
    test_watermark();
    test_short_packet();
    test_zlp();
    test_wrap();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
